pwm_meas: RTL and testbench

PWM_MEAS -- requirements
Module: pwm_meas

---
 rtl/pwm_meas_pkg.sv | 13 +
 rtl/pwm_edge_det.sv | 66 ++++++
 rtl/pwm_meas.sv | 141 ++++++++++++++
 tb/tb_pwm_meas.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_meas_pkg.sv
// Shared types and default constants for the PWM period/high-time measurement block.
package pwm_meas_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEF   = 20;
    localparam int unsigned TIMEOUT_DEF = 1000000;

endpackage

// File: rtl/pwm_edge_det.sv
// Two-flop synchroniser, optional 3-sample glitch filter and rise/fall detector for pwm_in.
// Optional feature: define PWM_MEAS_GLITCH_FILT_EN to enable the glitch filter.
module pwm_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic lvl,
    output logic rise,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef PWM_MEAS_GLITCH_FILT_EN
    logic [1:0] hist;
    logic       filt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist   <= '0;
            filt_q <= 1'b0;
        end else begin
            hist   <= {hist[0], sync2};
            filt_q <= lvl;
        end
    end

    // Level follows sync2 once three consecutive samples agree; otherwise it holds.
    always_comb begin
        lvl = filt_q;
        if ((sync2 == hist[0]) && (hist[0] == hist[1])) begin
            lvl = sync2;
        end
    end
`else
    always_comb begin
        lvl = sync2;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= lvl;
        end
    end

    always_comb begin
        rise = lvl & ~prev;
        fall = ~lvl & prev;
    end

endmodule

// File: rtl/pwm_meas.sv
// PWM period / high-time meter with idle timeout and stuck-level report.
// Optional feature: define PWM_MEAS_GLITCH_FILT_EN to filter pulses shorter than 3 clk.
module pwm_meas
    import pwm_meas_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid_o,
    output logic             timeout_o,
    output logic             stuck_lvl_o
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    if ((TIMEOUT < 2) || (64'(TIMEOUT) >= (64'd1 << CNT_W))) begin : g_bad_timeout
        $error("pwm_meas: TIMEOUT out of range for CNT_W");
    end

    logic lvl;
    logic rise;
    logic fall;

    pwm_edge_det u_edge_det (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] pcnt_n;
    logic [CNT_W-1:0] high_lat;
    logic [CNT_W-1:0] high_lat_n;
    logic [CNT_W-1:0] period_n;
    logic [CNT_W-1:0] high_n;
    logic             valid_n;
    logic             timeout_n;
    logic             stuck_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            pcnt         <= '0;
            high_lat     <= '0;
            period_o     <= '0;
            high_o       <= '0;
            meas_valid_o <= 1'b0;
            timeout_o    <= 1'b0;
            stuck_lvl_o  <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            pcnt         <= pcnt_n;
            high_lat     <= high_lat_n;
            period_o     <= period_n;
            high_o       <= high_n;
            meas_valid_o <= valid_n;
            timeout_o    <= timeout_n;
            stuck_lvl_o  <= stuck_n;
        end
    end

    always_comb begin
        state_n    = state;
        high_lat_n = high_lat;
        period_n   = period_o;
        high_n     = high_o;
        valid_n    = 1'b0;
        timeout_n  = timeout_o;
        stuck_n    = stuck_lvl_o;

        if (rise || fall) begin
            cnt_n = ONE;
        end else if (cnt == TO_VAL) begin
            cnt_n = cnt;
        end else begin
            cnt_n = cnt + ONE;
        end

        if (rise) begin
            pcnt_n = ONE;
        end else if (pcnt == TO_VAL) begin
            pcnt_n = pcnt;
        end else begin
            pcnt_n = pcnt + ONE;
        end

        if (rise) begin
            timeout_n = 1'b0;
        end

        // high_lat holds the width until the closing rise so both outputs publish together.
        unique case (state)
            IDLE: begin
                if (rise) begin
                    state_n = HIGH;
                end
            end
            HIGH: begin
                if (fall) begin
                    state_n    = LOW;
                    high_lat_n = cnt;
                end else if (cnt == TO_VAL) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                    stuck_n   = lvl;
                end
            end
            LOW: begin
                if (rise) begin
                    state_n  = HIGH;
                    period_n = pcnt;
                    high_n   = high_lat;
                    valid_n  = 1'b1;
                end else if (cnt == TO_VAL) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                    stuck_n   = lvl;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_meas.sv
// Scoreboard bench for pwm_meas: expected measurements queued at each driven rise, compared on meas_valid_o.
module tb_pwm_meas;

`ifdef PWM_MEAS_GLITCH_FILT_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [19:0] period_o;
    logic [19:0] high_o;
    logic        meas_valid_o;
    logic        timeout_o;
    logic        stuck_lvl_o;
    logic [19:0] l_period_o;
    logic [19:0] l_high_o;
    logic        l_meas_valid_o;
    logic        l_timeout_o;
    logic        l_stuck_lvl_o;

    pwm_meas #(.CNT_W(20), .TIMEOUT(300)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .period_o     (period_o),
        .high_o       (high_o),
        .meas_valid_o (meas_valid_o),
        .timeout_o    (timeout_o),
        .stuck_lvl_o  (stuck_lvl_o)
    );

    pwm_meas #(.CNT_W(20), .TIMEOUT(1000)) dut_long (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .period_o     (l_period_o),
        .high_o       (l_high_o),
        .meas_valid_o (l_meas_valid_o),
        .timeout_o    (l_timeout_o),
        .stuck_lvl_o  (l_stuck_lvl_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int period;
        int high;
    } meas_t;

    meas_t sb_q[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    bit    sb_armed = 1'b0;
    int    prev_period = 0;
    int    prev_high = 0;
    bit    chk_interval = 1'b0;
    int    last_valid_cyc = -1;
    int    long_valid_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        meas_t m;
        if (l_meas_valid_o === 1'b1) long_valid_cnt++;
        if (meas_valid_o === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid: meas_valid_o=1 at cycle %0d (period_o=%0d high_o=%0d), required 0",
                         cyc, period_o, high_o);
            end else begin
                m = sb_q.pop_front();
                if (period_o !== 20'(m.period)) begin
                    errors++;
                    $display("FAIL sb_period: got %0d, required %0d (cycle %0d)", period_o, m.period, cyc);
                end
                checks++;
                if (high_o !== 20'(m.high)) begin
                    errors++;
                    $display("FAIL sb_high: got %0d, required %0d (cycle %0d)", high_o, m.high, cyc);
                end
                if (chk_interval && last_valid_cyc >= 0) begin
                    checks++;
                    if (cyc - last_valid_cyc !== 100) begin
                        errors++;
                        $display("FAIL valid_interval: got %0d, required 100", cyc - last_valid_cyc);
                    end
                end
                last_valid_cyc = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rise_edge();
        if (sb_armed) sb_q.push_back('{prev_period, prev_high});
        pwm_in = 1'b1;
    endtask

    task automatic pwm_cycle(input int high, input int period);
        rise_edge();
        tick(high);
        pwm_in = 1'b0;
        tick(period - high);
        prev_period = period;
        prev_high   = high;
        sb_armed    = 1'b1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(3);
        rst            = 1'b0;
        sb_armed       = 1'b0;
        last_valid_cyc = -1;
    endtask

    task automatic drain(input string name);
        tick(LAT + 3);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_valid: got %0d outstanding, required 0", name, sb_q.size());
        end
        sb_q.delete();
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        pwm_in = 1'b0;
        tick(2);
        checks++;
        if (period_o !== 20'd0) begin errors++; $display("FAIL rst_period: got %0d, required 0", period_o); end
        checks++;
        if (high_o !== 20'd0) begin errors++; $display("FAIL rst_high: got %0d, required 0", high_o); end
        checks++;
        if (meas_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, required 0", meas_valid_o); end
        checks++;
        if (timeout_o !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b, required 0", timeout_o); end
        checks++;
        if (stuck_lvl_o !== 1'b0) begin errors++; $display("FAIL rst_stuck: got %b, required 0", stuck_lvl_o); end
        checks++;
        if (l_timeout_o !== 1'b0) begin errors++; $display("FAIL rst_long_timeout: got %b, required 0", l_timeout_o); end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_free_run();
        do_reset();
        chk_interval = 1'b1;
        repeat (10) pwm_cycle(37, 100);
        drain("free_run");
        chk_interval = 1'b0;
    endtask

    task automatic test_duty_sweep();
        do_reset();
        for (int h = 10; h <= 90; h += 10) pwm_cycle(h, 100);
        drain("sweep");
        tick(400);
        checks++;
        if (timeout_o !== 1'b1) begin errors++; $display("FAIL sweep0_timeout: got %b, required 1", timeout_o); end
        checks++;
        if (stuck_lvl_o !== 1'b0) begin errors++; $display("FAIL sweep0_stuck: got %b, required 0", stuck_lvl_o); end
        checks++;
        if (period_o !== 20'd100) begin errors++; $display("FAIL sweep0_period_hold: got %0d, required 100", period_o); end
        checks++;
        if (high_o !== 20'd80) begin errors++; $display("FAIL sweep0_high_hold: got %0d, required 80", high_o); end
        sb_armed = 1'b0;
        rise_edge();
        tick(LAT - 1);
        checks++;
        if (timeout_o !== 1'b1) begin errors++; $display("FAIL sweep100_timeout_early_clear: got %b, required 1", timeout_o); end
        tick(1);
        checks++;
        if (timeout_o !== 1'b0) begin errors++; $display("FAIL sweep100_timeout_clear: got %b, required 0", timeout_o); end
        tick(400);
        checks++;
        if (timeout_o !== 1'b1) begin errors++; $display("FAIL sweep100_timeout: got %b, required 1", timeout_o); end
        checks++;
        if (stuck_lvl_o !== 1'b1) begin errors++; $display("FAIL sweep100_stuck: got %b, required 1", stuck_lvl_o); end
        checks++;
        if (period_o !== 20'd100 || high_o !== 20'd80) begin
            errors++;
            $display("FAIL sweep100_hold: got period=%0d high=%0d, required 100/80", period_o, high_o);
        end
        pwm_in = 1'b0;
        drain("sweep_end");
    endtask

    task automatic test_stuck_high();
        int base;
        do_reset();
        repeat (3) pwm_cycle(37, 100);
        rise_edge();
        sb_armed = 1'b0;
        tick(LAT + 999);
        checks++;
        if (l_timeout_o !== 1'b0) begin errors++; $display("FAIL stuck_timeout_early: got %b, required 0", l_timeout_o); end
        tick(1);
        checks++;
        if (l_timeout_o !== 1'b1) begin errors++; $display("FAIL stuck_timeout: got %b, required 1", l_timeout_o); end
        checks++;
        if (l_stuck_lvl_o !== 1'b1) begin errors++; $display("FAIL stuck_level: got %b, required 1", l_stuck_lvl_o); end
        checks++;
        if (l_period_o !== 20'd100) begin errors++; $display("FAIL stuck_period_hold: got %0d, required 100", l_period_o); end
        checks++;
        if (l_high_o !== 20'd37) begin errors++; $display("FAIL stuck_high_hold: got %0d, required 37", l_high_o); end
        tick(2000 - (LAT + 1000));
        pwm_in = 1'b0;
        tick(50);
        base = long_valid_cnt;
        rise_edge();
        tick(LAT - 1);
        checks++;
        if (l_timeout_o !== 1'b1) begin errors++; $display("FAIL stuck_clear_early: got %b, required 1", l_timeout_o); end
        tick(1);
        checks++;
        if (l_timeout_o !== 1'b0) begin errors++; $display("FAIL stuck_clear: got %b, required 0", l_timeout_o); end
        tick(60);
        pwm_in = 1'b0;
        tick(40);
        checks++;
        if (long_valid_cnt !== base) begin
            errors++;
            $display("FAIL stuck_no_valid: got %0d pulses, required 0", long_valid_cnt - base);
        end
        drain("stuck");
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (2) pwm_cycle(37, 100);
        rise_edge();
        tick(20);
        rst = 1'b1;
        tick(1);
        checks++;
        if (period_o !== 20'd0 || high_o !== 20'd0) begin
            errors++;
            $display("FAIL midrst_meas: got period=%0d high=%0d, required 0/0", period_o, high_o);
        end
        checks++;
        if (meas_valid_o !== 1'b0 || timeout_o !== 1'b0 || stuck_lvl_o !== 1'b0) begin
            errors++;
            $display("FAIL midrst_flags: got valid=%b timeout=%b stuck=%b, required 0/0/0",
                     meas_valid_o, timeout_o, stuck_lvl_o);
        end
        rst      = 1'b0;
        sb_armed = 1'b0;
        // pwm_in still high: the cleared synchroniser sees this as the first rise after reset.
        tick(17);
        pwm_in = 1'b0;
        tick(63);
        prev_period = 80;
        prev_high   = 17;
        sb_armed    = 1'b1;
        repeat (2) pwm_cycle(37, 100);
        drain("midrst");
    endtask

    task automatic test_glitch();
        do_reset();
        repeat (2) pwm_cycle(37, 100);
        rise_edge();
        tick(37);
        pwm_in = 1'b0;
        tick(10);
`ifndef PWM_MEAS_GLITCH_FILT_EN
        sb_q.push_back('{47, 37});
`endif
        pwm_in = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(51);
`ifdef PWM_MEAS_GLITCH_FILT_EN
        prev_period = 100;
        prev_high   = 37;
`else
        prev_period = 53;
        prev_high   = 2;
`endif
        sb_armed = 1'b1;
        repeat (2) pwm_cycle(37, 100);
        drain("glitch");
    endtask

    initial begin : watchdog
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_free_run();
        test_duty_sweep();
        test_stuck_high();
        test_reset_mid();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
